// File: rtl/clock_pkg.sv
// Shared definitions for the clock board display path: segment patterns,
// service one-hot codes, scheduler state encoding and the arbitration helper.
package clock_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ALL   = 7'h00;

  localparam logic [3:0] SERVICE1 = 4'b1000;
  localparam logic [3:0] SERVICE2 = 4'b0100;
  localparam logic [3:0] SERVICE3 = 4'b0010;
  localparam logic [3:0] SERVICE4 = 4'b0001;

  typedef logic [0:0] state_t;
  localparam state_t S_BLANK = 1'b0;
  localparam state_t S_DRIVE = 1'b1;

  // Strict priority: service 1 (bit 3) always wins, zero means idle source.
  function automatic logic [3:0] pickGrant(input logic [3:0] req);
    if (req[3])      return SERVICE1;
    else if (req[2]) return SERVICE2;
    else if (req[1]) return SERVICE3;
    else if (req[0]) return SERVICE4;
    else             return 4'b0000;
  endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Bundle of requester inputs and display outputs shared by the scheduler
// and whatever drives it.
interface display_scheduler_if;

  logic [3:0]  req;
  logic [63:0] val;
  logic [15:0] blink;
  logic [15:0] idle_val;
  logic        alarm_on;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic [3:0]  grant;
  logic        frame_done;

  modport master (
    output req, val, blink, idle_val, alarm_on,
    input  anode, seg, grant, frame_done
  );

  modport slave (
    input  req, val, blink, idle_val, alarm_on,
    output anode, seg, grant, frame_done
  );

endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low 7-segment pattern; codes above 9 blank.
module bcd_to_seg
  import clock_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Table lookup with blank as the fallback for non-decimal codes.
  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scheduler.sv
// Time-multiplexed scan controller for the 4-digit display: arbitrates the
// requesters once per frame, latches a frame buffer, scans digits with a
// blanking gap, and applies blink masks and the alarm flash override.
module display_scheduler
  import clock_pkg::*;
#(
  parameter int SCAN_DIV  = 4,
  parameter int BLANK_CYC = 1,
  parameter int BLINK_DIV = 2
) (
  input logic               clk,
  input logic               resetn,
  display_scheduler_if.slave bus
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int FCNT_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CNT_W-1:0]  SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST  = FCNT_W'(BLINK_DIV - 1);

  state_t            state_q, state_d;
  logic [1:0]        dig_q, dig_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              blinkPhase_q, blinkPhase_d;
  logic [15:0]       frameVal_q, frameVal_d;
  logic [3:0]        frameBlink_q, frameBlink_d;
  logic [3:0]        grant_q, grant_d;
  logic              frameDone_q;
  logic [3:0]        anode_q, anode_d;
  logic [6:0]        seg_q, seg_d;

  logic              boundary;
  logic [3:0]        grantNext;
  logic [3:0]        curNibble;
  logic              curBlink;
  logic [6:0]        decSeg;

  assign boundary  = (state_q == S_DRIVE) && (cnt_q == SCAN_LAST) && (dig_q == 2'd3);
  assign grantNext = pickGrant(bus.req);
  assign curNibble = frameVal_q[{dig_q, 2'b00} +: 4];
  assign curBlink  = frameBlink_q[dig_q];

  bcd_to_seg u_bcdToSeg (
    .bcd_i (curNibble),
    .seg_o (decSeg)
  );

  // Scan sequencer: blank gap, then drive the current digit, then advance.
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q;
    if (state_q == S_BLANK) begin
      if (cnt_q == BLANK_LAST) begin
        state_d = S_DRIVE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      if (cnt_q == SCAN_LAST) begin
        state_d = S_BLANK;
        cnt_d   = '0;
        dig_d   = dig_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Frame boundary work: arbitrate, latch the winner's data, advance blink timing.
  always_comb begin
    grant_d      = grant_q;
    frameVal_d   = frameVal_q;
    frameBlink_d = frameBlink_q;
    fcnt_d       = fcnt_q;
    blinkPhase_d = blinkPhase_q;
    if (boundary) begin
      grant_d      = grantNext;
      frameVal_d   = bus.idle_val;
      frameBlink_d = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (grantNext[i]) begin
          frameVal_d   = bus.val[16*i +: 16];
          frameBlink_d = bus.blink[4*i +: 4];
        end
      end
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d       = '0;
        blinkPhase_d = ~blinkPhase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Output pattern for the coming cycle: alarm beats blink beats decoded digit.
  always_comb begin
    anode_d = 4'b1111;
    seg_d   = SEG_BLANK;
    if (state_q == S_DRIVE) begin
      anode_d = ~(4'b0001 << dig_q);
      if (bus.alarm_on) begin
        seg_d = SEG_ALL;
      end else if (curBlink && blinkPhase_q) begin
        seg_d = SEG_BLANK;
      end else begin
        seg_d = decSeg;
      end
    end
  end

  // State and registered outputs; reset blanks the display immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_BLANK;
      dig_q        <= 2'd0;
      cnt_q        <= '0;
      fcnt_q       <= '0;
      blinkPhase_q <= 1'b0;
      frameVal_q   <= 16'h0000;
      frameBlink_q <= 4'b0000;
      grant_q      <= 4'b0000;
      frameDone_q  <= 1'b0;
      anode_q      <= 4'b1111;
      seg_q        <= SEG_BLANK;
    end else begin
      state_q      <= state_d;
      dig_q        <= dig_d;
      cnt_q        <= cnt_d;
      fcnt_q       <= fcnt_d;
      blinkPhase_q <= blinkPhase_d;
      frameVal_q   <= frameVal_d;
      frameBlink_q <= frameBlink_d;
      grant_q      <= grant_d;
      frameDone_q  <= boundary;
      anode_q      <= anode_d;
      seg_q        <= seg_d;
    end
  end

  assign bus.anode      = anode_q;
  assign bus.seg        = seg_q;
  assign bus.grant      = grant_q;
  assign bus.frame_done = frameDone_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler: a frame-arithmetic reference model
// predicts every output cycle, a monitor compares on the falling edge.
module tb_display_scheduler;

  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 1;
  localparam int BLINK_DIV = 2;
  localparam int SLOT      = BLANK_CYC + SCAN_DIV;
  localparam int FRAME     = 4 * SLOT;

  logic clk    = 1'b0;
  logic resetn = 1'b1;

  display_scheduler_if bus ();

  display_scheduler #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] seg;
    logic [3:0] grant;
    logic       frameDone;
    logic       drive;
  } exp_t;

  exp_t expQ[$];
  int tests = 0;
  int fails = 0;

  int         idx;
  logic [15:0] mVal;
  logic [3:0]  mBlink;
  logic [3:0]  mGrant;

  // Reference decode table for active-low segments.
  function automatic logic [6:0] refSeg(input logic [3:0] n);
    case (n)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [15:0] randWord(input bit anyNibble);
    logic [15:0] w;
    for (int i = 0; i < 4; i++) begin
      if (anyNibble) w[4*i +: 4] = 4'($urandom_range(15, 0));
      else           w[4*i +: 4] = 4'($urandom_range(9, 0));
    end
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [63:0] val,
                               input logic [15:0] blink, input logic [15:0] idleVal,
                               input logic alarm);
    @(negedge clk);
    bus.req      = req;
    bus.val      = val;
    bus.blink    = blink;
    bus.idle_val = idleVal;
    bus.alarm_on = alarm;
  endtask

  // Reference model: output cycle idx follows from its position in the frame.
  always @(posedge clk or negedge resetn) begin : model
    exp_t e;
    int p, slot, s, phase;
    if (!resetn) begin
      idx    = 0;
      mVal   = '0;
      mBlink = '0;
      mGrant = '0;
      expQ.delete();
    end else begin
      p     = idx % FRAME;
      slot  = p / SLOT;
      s     = p % SLOT;
      phase = ((idx / FRAME) / BLINK_DIV) % 2;
      e.frameDone = (p == FRAME - 1);
      e.anode     = 4'hF;
      e.seg       = 7'h7F;
      e.drive     = 1'b0;
      if (s >= BLANK_CYC) begin
        e.drive       = 1'b1;
        e.anode[slot] = 1'b0;
        if (bus.alarm_on)                    e.seg = 7'h00;
        else if (mBlink[slot] && phase == 1) e.seg = 7'h7F;
        else                                 e.seg = refSeg(mVal[slot*4 +: 4]);
      end
      if (p == FRAME - 1) begin
        mGrant = 4'b0000;
        mVal   = bus.idle_val;
        mBlink = 4'b0000;
        for (int k = 3; k >= 0; k--) begin
          if (bus.req[k] && mGrant == 4'b0000) begin
            mGrant    = 4'b0000;
            mGrant[k] = 1'b1;
            mVal      = bus.val[16*k +: 16];
            mBlink    = bus.blink[4*k +: 4];
          end
        end
      end
      e.grant = mGrant;
      expQ.push_back(e);
      idx++;
    end
  end

  // Monitor: pop one prediction per output cycle and compare.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetn && expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("anode", 32'(bus.anode), 32'(e.anode));
      if (e.drive) checkOutput("seg", 32'(bus.seg), 32'(e.seg));
      checkOutput("grant", 32'(bus.grant), 32'(e.grant));
      checkOutput("frame_done", 32'(bus.frame_done), 32'(e.frameDone));
    end
  end

  initial begin
    logic [63:0] v;
    logic [15:0] b;
    bit found;
    bus.req      = 4'b0000;
    bus.val      = '0;
    bus.blink    = '0;
    bus.idle_val = 16'h1234;
    bus.alarm_on = 1'b0;
    #1 resetn = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset anode", 32'(bus.anode), 32'h0000000F);
    checkOutput("reset seg", 32'(bus.seg), 32'h0000007F);
    checkOutput("reset grant", 32'(bus.grant), 32'h0);
    checkOutput("reset frame_done", 32'(bus.frame_done), 32'h0);
    #1 resetn = 1'b1;

    // Idle source
    repeat (3 * FRAME) @(negedge clk);

    // Priority arbitration, then drop service 1 mid-frame
    v = {randWord(0), randWord(0), randWord(0), randWord(0)};
    applyStimulus(4'b1011, v, 16'h0000, 16'h1234, 1'b0);
    found = 0;
    for (int c = 0; c < 2 * FRAME && !found; c++) begin
      @(negedge clk);
      if (bus.frame_done) found = 1;
    end
    if (!found) begin
      fails++;
      tests++;
      $display("[TB] FAIL frame_done timeout: got none, expected pulse within %0d cycles", 2 * FRAME);
    end
    repeat (8) @(negedge clk);
    applyStimulus(4'b0011, v, 16'h0000, 16'h1234, 1'b0);
    repeat (2 * FRAME) @(negedge clk);

    // Blink on service 2, digits 0-1
    b = 16'($urandom);
    b[11:8] = 4'b0011;
    applyStimulus(4'b0100, {randWord(0), randWord(0), randWord(0), randWord(0)}, b, 16'h0987, 1'b0);
    repeat (8 * FRAME) @(negedge clk);

    // Alarm override toggling through drive and blank slots
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      if (c % 7 == 3) bus.alarm_on = ~bus.alarm_on;
    end
    bus.alarm_on = 1'b0;

    // Invalid nibble on service 3
    applyStimulus(4'b0010, {16'h1111, 16'h2222, 16'h9C05, 16'h4444}, 16'h0000, 16'h0000, 1'b0);
    repeat (3 * FRAME) @(negedge clk);

    // Randomized traffic
    for (int c = 0; c < 40 * FRAME; c++) begin
      @(negedge clk);
      if ($urandom_range(15, 0) == 0) bus.req = 4'($urandom);
      if ($urandom_range(7, 0) == 0)  bus.val[16*$urandom_range(3, 0) +: 16] = randWord($urandom_range(1, 0) == 1);
      if ($urandom_range(7, 0) == 0)  bus.blink = 16'($urandom);
      if ($urandom_range(31, 0) == 0) bus.idle_val = randWord(0);
      if ($urandom_range(19, 0) == 0) bus.alarm_on = ~bus.alarm_on;
    end
    bus.alarm_on = 1'b0;

    // Reset asserted while digit 2 is driven
    found = 0;
    for (int c = 0; c < 2 * FRAME && !found; c++) begin
      @(negedge clk);
      if (bus.anode == 4'b1011) found = 1;
    end
    if (!found) begin
      fails++;
      tests++;
      $display("[TB] FAIL digit2 timeout: got none, expected anode 4'b1011 within %0d cycles", 2 * FRAME);
    end
    #2 resetn = 1'b0;
    #1;
    checkOutput("midreset anode", 32'(bus.anode), 32'h0000000F);
    checkOutput("midreset seg", 32'(bus.seg), 32'h0000007F);
    checkOutput("midreset grant", 32'(bus.grant), 32'h0);
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    found = 0;
    for (int c = 0; c < 2 * SLOT && !found; c++) begin
      @(negedge clk);
      if (bus.anode != 4'hF) found = 1;
    end
    checkOutput("restart digit", 32'(bus.anode), 32'h0000000E);
    repeat (3 * FRAME) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
